// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The optional FETCH_PERF_CNT_EN build macro is consumed by instr_fetch_unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] PC_INC            = 32'd4;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Sequential successor address; wraps naturally at 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus.
// master = fetch unit, slave = instruction memory.
interface imem_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ack, input  imem_rdata);
  modport slave  (input  imem_req, input  imem_addr,
                  output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} skid buffer: catches an instruction that arrives
// while the pipeline is stalled so the memory request can retire.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  fetch_entry_t entry_q, entry_d;
  logic         full_q, full_d;

  // Clear beats load beats unload; payload only changes on load.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    entry_d = entry_q;
    full_d  = full_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      entry_d = din;
      full_d  = 1'b1;
    end else if (unload) begin
      full_d = 1'b0;
    end
  end

  // Buffer state register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the payload is reset as well; with a single entry this is cheap and keeps it X-free.
    if (!rst) begin
      entry_q <= '0;
      full_q  <= 1'b0;
    end else begin
      entry_q <= entry_d;
      full_q  <= full_d;
    end
  end

  assign dout = entry_q;
  assign full = full_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: PC, imem request FSM, IF/ID output registers.
// Build option: FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  imem_if.master      imem,
  output logic [31:0] instruction_out,
  output logic [31:0] PCNow_out,
  output logic [31:0] PCNext4_out,
  output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  disc_addr_q, disc_addr_d;  // address of the request being thrown away
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_now_q, pc_now_d;
  logic [31:0]  pc_next4_q, pc_next4_d;
  logic         valid_q, valid_d;

  logic         req;
  logic         ack;
  logic         skid_load, skid_unload, skid_clear, skid_full;
  fetch_entry_t skid_din, skid_dout;

  // A request is outstanding in REQ and DISCARD; DISCARD keeps the old address.
  assign req            = (state_q == ST_REQ) || (state_q == ST_DISCARD);
  assign ack            = imem.imem_ack && req;
  assign imem.imem_req  = req;
  assign imem.imem_addr = (state_q == ST_DISCARD) ? disc_addr_q : pc_q;

  assign skid_din.instr = imem.imem_rdata;
  assign skid_din.pc    = pc_q;

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .din    (skid_din),
    .dout   (skid_dout),
    .full   (skid_full)
  );

  // Next state, PC and output registers; a redirect overrides stall and ack.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    disc_addr_d = disc_addr_q;
    instr_d     = instr_q;
    pc_now_d    = pc_now_q;
    pc_next4_d  = pc_next4_q;
    valid_d     = valid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    if (branch_taken) begin
      pc_d       = align_word(branch_target);
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      skid_clear = 1'b1;
      if (state_q == ST_REQ && !ack) begin
        // The in-flight fetch must still complete; drop its data later.
        state_d     = ST_DISCARD;
        disc_addr_d = pc_q;
      end else if (state_q == ST_DISCARD && !ack) begin
        state_d = ST_DISCARD;
      end else begin
        state_d = ST_REQ;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (stall) begin
            if (ack) begin
              skid_load = 1'b1;
              pc_d      = pc_inc(pc_q);
              state_d   = ST_HOLD;
            end
          end else if (ack) begin
            instr_d    = imem.imem_rdata;
            pc_now_d   = pc_q;
            pc_next4_d = pc_inc(pc_q);
            valid_d    = 1'b1;
            pc_d       = pc_inc(pc_q);
          end else begin
            valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall && skid_full) begin
            instr_d     = skid_dout.instr;
            pc_now_d    = skid_dout.pc;
            pc_next4_d  = pc_inc(skid_dout.pc);
            valid_d     = 1'b1;
            skid_unload = 1'b1;
            state_d     = ST_REQ;
          end
        end
        ST_DISCARD: begin
          if (ack) state_d = ST_REQ;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, PC and IF/ID output registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      disc_addr_q <= RESET_PC;
      instr_q     <= NOP_INSTR;
      pc_now_q    <= 32'h0;
      pc_next4_q  <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      disc_addr_q <= disc_addr_d;
      instr_q     <= instr_d;
      pc_now_q    <= pc_now_d;
      pc_next4_q  <= pc_next4_d;
      valid_q     <= valid_d;
    end
  end

  assign instruction_out = instr_q;
  assign PCNow_out       = pc_now_q;
  assign PCNext4_out     = pc_next4_q;
  assign valid_out       = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        fetched_now;
  logic        stalled_now;

  assign fetched_now = !branch_taken && !stall &&
                       ((state_q == ST_REQ && ack) || (state_q == ST_HOLD && skid_full));
  assign stalled_now = (req && !imem.imem_ack) || (state_q == ST_HOLD);

  // Free-running event counters; wrap at 2^32.
  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'd0, fetched_now};
    perf_stall_d   = perf_stall_q + {31'd0, stalled_now};
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= 32'h0;
      perf_stall_q   <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
